word_port_bridge: RTL and testbench

- Host-facing engine that moves full WORDSZ-bit register-file words into and out of a multi-core micro_top through its narrow PORTW-bit serial port.
- Also launches functions (funcid/start) and times them until busy falls.
- Generalises serial word transfer with parametrised word, port and core counts, broadcast write, read-valid tracking with timeout, and a cycle counter.
- Sits between a host command FIFO/CSR and micro_top.

---
 rtl/word_port_pkg.sv | 27 ++
 rtl/word_port_gather.sv | 59 +++++
 rtl/word_port_bridge.sv | 233 +++++++++++++++++++++++
 tb/tb_word_port_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_port_pkg.sv
// word_port_pkg: shared types for the word/port bridge.
// Command ops, engine states and the serial beat-count helper.
package word_port_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_RUN   = 2'd2,
    OP_RSV   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_DRAIN,
    S_RUN_ARM,
    S_RUN_BUSY,
    S_RESP
  } state_e;

  // Port beats needed to carry one register-file word.
  function automatic int ser_sz(input int wordsz, input int portw);
    return (wordsz + portw - 1) / portw;
  endfunction

endpackage

// File: rtl/word_port_gather.sv
// word_port_gather: collects serial read beats into one word.
// Ports: clk/rst, i_clr (new command), i_cap_en (beats may land),
// i_tmo_en (drain phase), i_rdata/i_rdata_valid (port beats),
// o_done (all beats in), o_tmo (drain expired), o_data (word).
module word_port_gather
  import word_port_pkg::*;
#(
  parameter int WORDSZ     = 384,
  parameter int PORTW      = 64,
  parameter int SERSZ      = 6,
  parameter int RD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_cap_en,
  input  logic              i_tmo_en,
  input  logic [PORTW-1:0]  i_rdata,
  input  logic              i_rdata_valid,
  output logic              o_done,
  output logic              o_tmo,
  output logic [WORDSZ-1:0] o_data
);

  localparam int SW   = $clog2(SERSZ + 1);
  localparam int TW   = $clog2(RD_TIMEOUT + 1);
  localparam int PADW = SERSZ * PORTW;

  logic [SW-1:0]   r_slot;
  logic [TW-1:0]   r_tmo;
  logic [PADW-1:0] r_asm;
  logic            w_take;

  // Beats past the last slot are dropped.
  assign w_take = i_cap_en && i_rdata_valid && !o_done;
  assign o_done = (r_slot == SW'(SERSZ));
  assign o_tmo  = (r_tmo == TW'(RD_TIMEOUT));
  assign o_data = r_asm[WORDSZ-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
      r_tmo  <= '0;
      r_asm  <= '0;
    end else if (i_clr) begin
      r_slot <= '0;
      r_tmo  <= '0;
      r_asm  <= '0;
    end else begin
      if (w_take) begin
        r_asm[int'(r_slot) * PORTW +: PORTW] <= i_rdata;
        r_slot <= r_slot + SW'(1);
      end
      if (i_tmo_en && !o_tmo)
        r_tmo <= r_tmo + TW'(1);
    end
  end

endmodule

// File: rtl/word_port_bridge.sv
// word_port_bridge: moves register-file words over a narrow serial
// port into micro_top cores and launches/times functions.
// Ports: req_* command in (valid/ready), rsp_* response out,
// chip_sel/wen/waddr/wdata/ren/raddr/rdata/rdata_valid serial port,
// funcid/start/busy function launch.
module word_port_bridge
  import word_port_pkg::*;
#(
  parameter int WORDSZ     = 384,
  parameter int PORTW      = 64,
  parameter int PORTAW     = 16,
  parameter int RFSZLOG2   = 8,
  parameter int BEATLOG2   = 5,
  parameter int CORE_NUM   = 4,
  parameter int CORELOG2   = 2,
  parameter int FUNCIDW    = 6,
  parameter int RD_TIMEOUT = 16,
  parameter int CYCW       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic                req_bcast,
  input  logic [CORELOG2-1:0] req_core,
  input  logic [RFSZLOG2-1:0] req_addr,
  input  logic [FUNCIDW-1:0]  req_funcid,
  input  logic [WORDSZ-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORDSZ-1:0]   rsp_rdata,
  output logic [CYCW-1:0]     rsp_cycles,
  output logic                rsp_err,
  output logic [CORELOG2-1:0] chip_sel,
  output logic                wen,
  output logic [PORTAW-1:0]   waddr,
  output logic [PORTW-1:0]    wdata,
  output logic                ren,
  output logic [PORTAW-1:0]   raddr,
  input  logic [PORTW-1:0]    rdata,
  input  logic                rdata_valid,
  output logic [FUNCIDW-1:0]  funcid,
  output logic                start,
  input  logic                busy
);

  localparam int SERSZ = ser_sz(WORDSZ, PORTW);
  localparam int BW    = $clog2(SERSZ + 1);
  localparam int PADW  = SERSZ * PORTW;

  state_e              r_state;
  state_e              w_next;
  logic                r_bcast;
  logic [CORELOG2-1:0] r_csel;
  logic [RFSZLOG2-1:0] r_addr;
  logic [FUNCIDW-1:0]  r_funcid;
  logic [PADW-1:0]     r_wpad;
  logic [BW-1:0]       r_beat;
  logic [CYCW-1:0]     r_cyc;
  logic                r_err;

  op_e                 w_op;
  logic                w_acc;
  logic                w_bad;
  logic                w_seq_end;
  logic                w_last_core;
  logic                w_arm_tmo;
  logic                w_g_done;
  logic                w_g_tmo;
  logic                w_cap_en;
  logic                w_tmo_en;
  logic [PORTAW-1:0]   w_beat_addr;
  logic [WORDSZ-1:0]   w_g_data;

  assign w_op      = op_e'(req_op);
  assign req_ready = (r_state == S_IDLE) && !rst;
  assign w_acc     = req_valid && req_ready;
  assign w_bad     = (w_op == OP_RSV) ||
                     (!req_bcast && 32'(req_core) >= CORE_NUM);

  assign w_seq_end   = (r_beat == BW'(SERSZ - 1));
  assign w_last_core = !r_bcast ||
                       (r_csel == CORELOG2'(CORE_NUM - 1));
  assign w_arm_tmo   = (r_cyc == CYCW'(RD_TIMEOUT - 1));
  assign w_beat_addr = (PORTAW'(r_addr) << BEATLOG2) +
                       PORTAW'(r_beat);

  assign w_cap_en = (r_state == S_RD_ISSUE) ||
                    (r_state == S_RD_DRAIN);
  assign w_tmo_en = (r_state == S_RD_DRAIN);

  word_port_gather #(
    .WORDSZ     (WORDSZ),
    .PORTW      (PORTW),
    .SERSZ      (SERSZ),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) u_gather (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (w_acc),
    .i_cap_en      (w_cap_en),
    .i_tmo_en      (w_tmo_en),
    .i_rdata       (rdata),
    .i_rdata_valid (rdata_valid),
    .o_done        (w_g_done),
    .o_tmo         (w_g_tmo),
    .o_data        (w_g_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_bad) w_next = S_RESP;
          else begin
            unique case (w_op)
              OP_WRITE: w_next = S_WR;
              OP_READ:  w_next = S_RD_ISSUE;
              OP_RUN:   w_next = S_RUN_ARM;
              default:  w_next = S_RESP;
            endcase
          end
        end
      end
      S_WR:
        if (w_seq_end && w_last_core) w_next = S_RESP;
      S_RD_ISSUE:
        if (w_seq_end) w_next = S_RD_DRAIN;
      S_RD_DRAIN:
        if (w_g_done || w_g_tmo) w_next = S_RESP;
      S_RUN_ARM:
        if (busy) w_next = S_RUN_BUSY;
        else if (w_arm_tmo) w_next = S_RESP;
      S_RUN_BUSY:
        if (!busy) w_next = S_RESP;
      S_RESP:
        if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    wen       = 1'b0;
    ren       = 1'b0;
    waddr     = '0;
    raddr     = '0;
    wdata     = '0;
    start     = 1'b0;
    funcid    = '0;
    rsp_valid = (r_state == S_RESP);
    unique case (r_state)
      S_WR: begin
        wen   = 1'b1;
        waddr = w_beat_addr;
        wdata = r_wpad[int'(r_beat) * PORTW +: PORTW];
      end
      S_RD_ISSUE: begin
        ren   = 1'b1;
        raddr = w_beat_addr;
      end
      S_RUN_ARM: begin
        start  = 1'b1;
        funcid = r_funcid;
      end
      default: ;
    endcase
  end

  assign chip_sel   = r_csel;
  assign rsp_rdata  = w_g_data;
  assign rsp_cycles = r_cyc;
  assign rsp_err    = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcast  <= 1'b0;
      r_csel   <= '0;
      r_addr   <= '0;
      r_funcid <= '0;
      r_wpad   <= '0;
      r_beat   <= '0;
      r_cyc    <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_bcast  <= req_bcast && (w_op == OP_WRITE);
            r_csel   <= (req_bcast && w_op == OP_WRITE) ?
                        '0 : req_core;
            r_addr   <= req_addr;
            r_funcid <= req_funcid;
            r_wpad   <= PADW'(req_wdata);
            r_beat   <= '0;
            r_cyc    <= '0;
            r_err    <= w_bad;
          end
        end
        S_WR: begin
          if (w_seq_end) begin
            r_beat <= '0;
            if (!w_last_core) r_csel <= r_csel + CORELOG2'(1);
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        S_RD_ISSUE:
          r_beat <= w_seq_end ? '0 : r_beat + BW'(1);
        S_RD_DRAIN:
          r_err <= w_g_tmo && !w_g_done;
        S_RUN_ARM: begin
          // The busy-rise cycle is itself the first busy cycle.
          if (busy) r_cyc <= CYCW'(1);
          else if (w_arm_tmo) begin
            r_cyc <= '0;
            r_err <= 1'b1;
          end else r_cyc <= r_cyc + CYCW'(1);
        end
        S_RUN_BUSY:
          if (busy && !(&r_cyc)) r_cyc <= r_cyc + CYCW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_word_port_bridge.sv
// tb_word_port_bridge: directed + random checks of word_port_bridge
// against a word-level memory model and a port-level device model.
module tb_word_port_bridge;

  localparam int WORDSZ = 384;
  localparam int PORTW = 64;
  localparam int SERSZ = 6;
  localparam int RD_TIMEOUT = 16;

  logic clk = 0;
  logic rst = 1;
  logic req_valid = 0;
  logic req_ready;
  logic [1:0] req_op = 0;
  logic req_bcast = 0;
  logic [1:0] req_core = 0;
  logic [7:0] req_addr = 0;
  logic [5:0] req_funcid = 0;
  logic [383:0] req_wdata = 0;
  logic rsp_valid;
  logic rsp_ready = 0;
  logic [383:0] rsp_rdata;
  logic [31:0] rsp_cycles;
  logic rsp_err;
  logic [1:0] chip_sel;
  logic wen;
  logic [15:0] waddr;
  logic [63:0] wdata;
  logic ren;
  logic [15:0] raddr;
  logic [63:0] rdata = 0;
  logic rdata_valid = 0;
  logic [5:0] funcid;
  logic start;
  logic busy = 0;

  word_port_bridge dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_bcast(req_bcast),
    .req_core(req_core), .req_addr(req_addr),
    .req_funcid(req_funcid), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_cycles(rsp_cycles),
    .rsp_err(rsp_err), .chip_sel(chip_sel),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata),
    .rdata_valid(rdata_valid), .funcid(funcid),
    .start(start), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 0;
  bit drop_last = 0;
  int last_ren_cyc = 0;
  int overlap = 0;
  int rsp_t = 0;

  logic [63:0] pmem [int];
  logic [383:0] ref_mem [int];
  logic [81:0] wq [$];

  typedef struct {
    int due;
    logic [63:0] d;
  } beat_t;
  beat_t rq [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Port device: write sink and read responder with set latency.
  always @(negedge clk) begin
    int key;
    beat_t b;
    rdata_valid = 0;
    rdata = '0;
    if (rst) rq.delete();
    if (wen && ren) overlap++;
    if (wen) begin
      wq.push_back({chip_sel, waddr, wdata});
      key = int'({chip_sel, waddr});
      pmem[key] = wdata;
    end
    if (ren) begin
      last_ren_cyc = cyc;
      key = int'({chip_sel, raddr});
      if (!(drop_last && raddr[4:0] == 5'(SERSZ - 1))) begin
        b.due = cyc + lat;
        b.d = pmem.exists(key) ? pmem[key] : 64'd0;
        rq.push_back(b);
      end
    end
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      rdata_valid = 1;
      rdata = rq[0].d;
      void'(rq.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [383:0] obs,
                     input logic [383:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [383:0] ref_rd(input int core,
                                          input int addr);
    int k = core * 256 + addr;
    return ref_mem.exists(k) ? ref_mem[k] : '0;
  endfunction

  task automatic send(input logic [1:0] op, input bit bc,
                      input logic [1:0] core, input logic [7:0] addr,
                      input logic [5:0] fid, input logic [383:0] w);
    int n = 0;
    req_valid = 1;
    req_op = op;
    req_bcast = bc;
    req_core = core;
    req_addr = addr;
    req_funcid = fid;
    req_wdata = w;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", req_ready, 1'b1);
    wq.delete();
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_rsp(input int maxc, output int waited);
    waited = 0;
    while (!rsp_valid && waited < maxc) begin
      @(negedge clk);
      waited++;
    end
    chk("rsp_seen", rsp_valid, 1'b1);
    rsp_t = cyc;
  endtask

  task automatic ack();
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_single", rsp_valid, 1'b0);
  endtask

  task automatic check_write(input int core, input int addr,
                             input logic [383:0] w, input bit bc);
    int ncore = bc ? 4 : 1;
    logic [81:0] e;
    chk("wr_nbeats", wq.size(), ncore * SERSZ);
    for (int c = 0; c < ncore; c++)
      for (int i = 0; i < SERSZ; i++)
        if (c * SERSZ + i < wq.size()) begin
          e = {2'(bc ? c : core), 16'((addr << 5) + i),
               w[i * 64 +: 64]};
          chk("wr_beat", wq[c * SERSZ + i], e);
        end
  endtask

  task automatic do_write(input int core, input int addr,
                          input logic [383:0] w, input bit bc);
    int wt;
    send(2'd0, bc, 2'(core), 8'(addr), 6'd0, w);
    wait_rsp(200, wt);
    chk("wr_err", rsp_err, 1'b0);
    check_write(core, addr, w, bc);
    if (bc) for (int c = 0; c < 4; c++) ref_mem[c * 256 + addr] = w;
    else ref_mem[core * 256 + addr] = w;
    ack();
  endtask

  task automatic do_read(input int core, input int addr,
                         input int l, input bit drop,
                         output logic [383:0] d, output logic e);
    int wt;
    lat = l;
    drop_last = drop;
    send(2'd1, 1'b0, 2'(core), 8'(addr), 6'd0, '0);
    wait_rsp(120, wt);
    d = rsp_rdata;
    e = rsp_err;
    ack();
    drop_last = 0;
  endtask

  logic [383:0] w0, w1, exp_w, rd;
  logic er;
  int wt, held, spur, diff;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outs",
        {wen, ren, start, rsp_valid, req_ready, chip_sel, funcid},
        '0);
    rst = 0;
    @(negedge clk);
    chk("idle_ready", req_ready, 1'b1);

    // WRITE core2 addr3, sequential bytes
    for (int k = 0; k < 48; k++) w0[k * 8 +: 8] = 8'(k + 1);
    do_write(2, 3, w0, 0);

    // Broadcast WRITE addr1, random word
    for (int k = 0; k < 12; k++) w1[k * 32 +: 32] = $urandom();
    do_write(0, 1, w1, 1);

    // READ back with several latencies
    do_read(2, 3, 2, 0, rd, er);
    chk("rd_lat2_data", rd, ref_rd(2, 3));
    chk("rd_lat2_err", er, 1'b0);
    do_read(2, 3, 0, 0, rd, er);
    chk("rd_lat0_data", rd, ref_rd(2, 3));
    chk("rd_lat0_err", er, 1'b0);
    do_read(2, 3, 5, 0, rd, er);
    chk("rd_lat5_data", rd, ref_rd(2, 3));
    chk("rd_lat5_err", er, 1'b0);
    do_read(3, 1, 1, 0, rd, er);
    chk("rd_bcast_c3", rd, ref_rd(3, 1));

    // READ with last beat dropped -> timeout, partial word
    do_read(0, 1, 1, 1, rd, er);
    exp_w = ref_rd(0, 1);
    exp_w[383:320] = '0;
    chk("rd_tmo_data", rd, exp_w);
    chk("rd_tmo_err", er, 1'b1);
    diff = rsp_t - last_ren_cyc;
    chk("rd_tmo_delay",
        diff >= RD_TIMEOUT && diff <= RD_TIMEOUT + 3, 1'b1);

    // Reserved op -> error next cycle, no port activity
    send(2'd3, 1'b0, 2'd1, 8'd7, 6'd0, '0);
    chk("bad_rsp_next", {rsp_valid, rsp_err}, 2'b11);
    chk("bad_no_port", {wen, ren, start}, 3'b000);
    ack();

    // RUN funcid=1, busy high 1000 cycles
    send(2'd2, 1'b0, 2'd0, 8'd0, 6'd1, '0);
    for (int k = 0; k < 3; k++) begin
      chk("arm_start", {start, funcid}, {1'b1, 6'd1});
      @(negedge clk);
    end
    busy = 1;
    @(negedge clk);
    chk("busy_start_low", {start, funcid}, '0);
    repeat (999) @(negedge clk);
    busy = 0;
    wait_rsp(10, wt);
    chk("run_cycles", rsp_cycles, 32'd1000);
    chk("run_err", rsp_err, 1'b0);
    ack();

    // RUN with no busy -> arm timeout
    send(2'd2, 1'b0, 2'd0, 8'd0, 6'd7, '0);
    wait_rsp(RD_TIMEOUT + 10, wt);
    chk("arm_tmo_err", rsp_err, 1'b1);
    chk("arm_tmo_start", start, 1'b0);
    chk("arm_tmo_wait",
        wt >= RD_TIMEOUT - 2 && wt <= RD_TIMEOUT + 2, 1'b1);
    ack();

    // Response held while rsp_ready low
    for (int k = 0; k < 12; k++) w0[k * 32 +: 32] = $urandom();
    send(2'd0, 1'b0, 2'd1, 8'd20, 6'd0, w0);
    wait_rsp(50, wt);
    held = 1;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid) held = 0;
    end
    chk("rsp_hold", held, 1);
    ref_mem[1 * 256 + 20] = w0;
    ack();

    // Reset pulse in the middle of a WRITE
    send(2'd0, 1'b0, 2'd1, 8'h80, 6'd0, w1);
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1 chk("rst_outs_zero",
           {wen, ren, start, rsp_valid, req_ready,
            chip_sel, waddr, wdata}, '0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    spur = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) spur = 1;
    end
    chk("rst_no_rsp", spur, 0);

    // Normal traffic after reset
    do_read(1, 20, 3, 0, rd, er);
    chk("post_rst_rd", rd, ref_rd(1, 20));

    // Random write/read pairs
    for (int it = 0; it < 6; it++) begin
      int c, a, l;
      c = $urandom_range(0, 3);
      a = $urandom_range(0, 255);
      l = $urandom_range(0, 4);
      for (int k = 0; k < 12; k++) w0[k * 32 +: 32] = $urandom();
      do_write(c, a, w0, 0);
      do_read(c, a, l, 0, rd, er);
      chk("rand_rd_data", rd, ref_rd(c, a));
      chk("rand_rd_err", er, 1'b0);
    end

    chk("wen_ren_excl", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
